// File: rtl/loadable_counter_if.sv
// Control and data bundle for loadable_counter. The bench drives it through the master modport;
// the counter uses the slave modport.
interface loadable_counter_if #(
  parameter int WIDTH = 9
);
  logic             CE;
  logic             LOAD;
  logic             RLDWR;
  logic             AUTO;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] CMP;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             TERM;
  logic             EVENT;

  modport master (
    output CE, LOAD, RLDWR, AUTO, D, CMP,
    input  Q, R, TERM, EVENT
  );

  modport slave (
    input  CE, LOAD, RLDWR, AUTO, D, CMP,
    output Q, R, TERM, EVENT
  );
endinterface

// File: rtl/loadable_counter.sv
// Up-counter with immediate load, compare, and auto-reload from R.
// Outputs: combinational terminal count (TERM) and a one-cycle registered EVENT strobe.
module loadable_counter #(
  parameter int WIDTH = 9
) (
  input logic              MasterClock,
  input logic              RESETL,
  loadable_counter_if.slave bus
);
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_event;
  logic             w_sel1;
  logic             w_sel0;
  logic             w_term;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_q_next;

  assign w_sel1 = bus.LOAD;
  assign w_sel0 = bus.CE & ~bus.LOAD;
  assign w_term = w_sel0 & (r_q == bus.CMP);

  // On terminal count in auto mode, the increment leg is fed from R instead of Q+1.
  assign w_inc = (w_term & bus.AUTO) ? r_r : (r_q + WIDTH'(1));

  always_comb begin
    w_q_next = r_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_q_next[i] = w_sel1 ? bus.D[i] : (w_sel0 ? w_inc[i] : r_q[i]);
    end
  end

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      r_q     <= '0;
      r_r     <= '0;
      r_event <= 1'b0;
    end else begin
      r_q     <= w_q_next;
      r_event <= w_term;
      if (bus.RLDWR) r_r <= bus.D;
    end
  end

  assign bus.Q     = r_q;
  assign bus.R     = r_r;
  assign bus.TERM  = w_term;
  assign bus.EVENT = r_event;
endmodule

// File: tb/tb_loadable_counter.sv
// Directed-vector bench for loadable_counter. Expected values are hand-computed.
module tb_loadable_counter;
  localparam int W = 9;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  loadable_counter_if #(.WIDTH(W)) bus ();

  loadable_counter #(.WIDTH(W)) dut (
    .MasterClock(clk),
    .RESETL     (rst_n),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge, so registered outputs have settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.CE    = 1'b0;
    bus.LOAD  = 1'b0;
    bus.RLDWR = 1'b0;
    bus.AUTO  = 1'b0;
    bus.D     = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    idle_inputs();
    bus.CMP  = 9'h100;
    #3;
    check("rst_q",     32'(bus.Q),     32'h0);
    check("rst_r",     32'(bus.R),     32'h0);
    check("rst_event", 32'(bus.EVENT), 32'h0);
    step();
    rst_n = 1'b1;

    // Bring Q to 0x155 with EVENT high, then reset asynchronously between edges.
    bus.LOAD = 1'b1; bus.RLDWR = 1'b1; bus.D = 9'h154;
    step();
    check("pre_q", 32'(bus.Q), 32'h154);
    check("pre_r", 32'(bus.R), 32'h154);
    idle_inputs();
    bus.CE = 1'b1; bus.CMP = 9'h154;
    #1;
    check("pre_term", 32'(bus.TERM), 32'h1);
    step();
    check("pre_q155",  32'(bus.Q),     32'h155);
    check("pre_event", 32'(bus.EVENT), 32'h1);
    bus.CE = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_q",     32'(bus.Q),     32'h0);
    check("async_r",     32'(bus.R),     32'h0);
    check("async_event", 32'(bus.EVENT), 32'h0);
    step();
    check("held_q",     32'(bus.Q),     32'h0);
    check("held_r",     32'(bus.R),     32'h0);
    check("held_event", 32'(bus.EVENT), 32'h0);
    rst_n = 1'b1;

    // Free run across the all-ones wrap.
    bus.CMP = 9'h100; bus.AUTO = 1'b0; bus.CE = 1'b1; bus.LOAD = 1'b1; bus.D = 9'h1FE;
    step();
    check("wrap_load", 32'(bus.Q), 32'h1FE);
    bus.LOAD = 1'b0;
    #1;
    check("wrap_term0", 32'(bus.TERM), 32'h0);
    step();
    check("wrap_1ff",   32'(bus.Q),    32'h1FF);
    check("wrap_term1", 32'(bus.TERM), 32'h0);
    step();
    check("wrap_000",   32'(bus.Q),    32'h000);
    check("wrap_term2", 32'(bus.TERM), 32'h0);
    step();
    check("wrap_001",   32'(bus.Q),    32'h001);

    // Auto-reload divider: 5,6,7,8,5,... period 4.
    idle_inputs();
    bus.RLDWR = 1'b1; bus.LOAD = 1'b1; bus.D = 9'h005;
    step();
    check("div_r", 32'(bus.R), 32'h5);
    idle_inputs();
    bus.CMP = 9'h008; bus.AUTO = 1'b1; bus.CE = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      check("div_q",     32'(bus.Q),     32'(5 + (k % 4)));
      check("div_term",  32'(bus.TERM),  32'((k % 4) == 3));
      check("div_event", 32'(bus.EVENT), 32'((k > 0) && ((k % 4) == 0)));
      step();
    end

    // Load beats a terminal count.
    idle_inputs();
    bus.LOAD = 1'b1; bus.D = 9'h008;
    step();
    bus.CE = 1'b1; bus.CMP = 9'h008; bus.LOAD = 1'b1; bus.D = 9'h0AA;
    #1;
    check("lp_term", 32'(bus.TERM), 32'h0);
    step();
    check("lp_q",     32'(bus.Q),     32'h0AA);
    check("lp_event", 32'(bus.EVENT), 32'h0);
    idle_inputs();

    // Reload write colliding with an auto-reload edge.
    bus.LOAD = 1'b1; bus.RLDWR = 1'b1; bus.D = 9'h010;
    step();
    bus.RLDWR = 1'b0; bus.D = 9'h020;
    step();
    check("col_setup_q", 32'(bus.Q), 32'h020);
    check("col_setup_r", 32'(bus.R), 32'h010);
    bus.LOAD = 1'b0; bus.CMP = 9'h020; bus.AUTO = 1'b1; bus.CE = 1'b1;
    bus.RLDWR = 1'b1; bus.D = 9'h030;
    #1;
    check("col_term", 32'(bus.TERM), 32'h1);
    step();
    check("col_q",     32'(bus.Q),     32'h010);
    check("col_r",     32'(bus.R),     32'h030);
    check("col_event", 32'(bus.EVENT), 32'h1);
    bus.RLDWR = 1'b0;
    repeat (16) step();
    check("col_q20",   32'(bus.Q),    32'h020);
    check("col_term2", 32'(bus.TERM), 32'h1);
    step();
    check("col_wrap", 32'(bus.Q), 32'h030);

    // CE gating.
    idle_inputs();
    bus.LOAD = 1'b1; bus.D = 9'h007;
    step();
    bus.LOAD = 1'b0; bus.CMP = 9'h007;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ceg_term", 32'(bus.TERM), 32'h0);
      step();
      check("ceg_q", 32'(bus.Q), 32'h007);
    end
    bus.CE = 1'b1;
    #1;
    check("ceg_term1", 32'(bus.TERM), 32'h1);
    step();
    check("ceg_q8",    32'(bus.Q),     32'h008);
    check("ceg_event", 32'(bus.EVENT), 32'h1);

    // Back-to-back terminal count with CMP == R.
    idle_inputs();
    bus.LOAD = 1'b1; bus.D = 9'h030; bus.CE = 1'b1; bus.AUTO = 1'b1; bus.CMP = 9'h030;
    step();
    bus.LOAD = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("b2b_term",  32'(bus.TERM),  32'h1);
      check("b2b_q",     32'(bus.Q),     32'h030);
      check("b2b_event", 32'(bus.EVENT), 32'(k > 0));
      step();
    end

    // CMP change takes effect combinationally.
    bus.AUTO = 1'b0; bus.CMP = 9'h031;
    #1;
    check("cmp_term0", 32'(bus.TERM), 32'h0);
    bus.CMP = 9'h030;
    #1;
    check("cmp_term1", 32'(bus.TERM), 32'h1);
    step();
    check("cmp_q", 32'(bus.Q), 32'h031);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
